// File: rtl/axi_rd_ctrl_mc_if.sv
`default_nettype none
// ============================================================================
// Module   : axi_rd_ctrl_mc_if
// Purpose  : User-request and AXI-command bundle for the multi-channel read
//            command generator.
// Revision : 1.0 - initial release
// ============================================================================
interface axi_rd_ctrl_mc_if #(
    parameter int P_CH_NUM         = 4,
    parameter int P_CH_ID_WIDTH    = 2,
    parameter int P_AXI_ADDR_WIDTH = 32
);
    logic [P_CH_NUM*P_AXI_ADDR_WIDTH-1:0] user_baddr;
    logic [P_CH_NUM*P_AXI_ADDR_WIDTH-1:0] user_faddr;
    logic [P_CH_NUM-1:0]                  user_valid;
    logic [P_CH_NUM-1:0]                  user_clr;
    logic [P_CH_NUM-1:0]                  user_busy;
    logic                                 axi_ready;
    logic                                 u2a_valid;
    logic [P_AXI_ADDR_WIDTH-1:0]          u2a_addr;
    logic [7:0]                           u2a_length;
    logic [P_CH_ID_WIDTH-1:0]             u2a_id;

    // Command generator side
    modport master (
        input  user_baddr, user_faddr, user_valid, user_clr, axi_ready,
        output user_busy, u2a_valid, u2a_addr, u2a_length, u2a_id
    );

    // User / AXI master side
    modport slave (
        output user_baddr, user_faddr, user_valid, user_clr, axi_ready,
        input  user_busy, u2a_valid, u2a_addr, u2a_length, u2a_id
    );
endinterface
`default_nettype wire

// File: rtl/axi_rd_ctrl_mc.sv
`default_nettype none
// ============================================================================
// Module   : axi_rd_ctrl_mc
// Purpose  : Round-robin multi-channel read-burst command generator over
//            circular per-channel DDR regions, optional short tail burst.
// Revision : 1.0 - initial release
// ============================================================================
module axi_rd_ctrl_mc #(
    parameter int P_CH_NUM         = 4,
    parameter int P_CH_ID_WIDTH    = 2,
    parameter int P_RD_LENGTH      = 4096,
    parameter int P_AXI_DATA_WIDTH = 128,
    parameter int P_AXI_ADDR_WIDTH = 32,
    parameter int P_TAIL_EN        = 0
)(
    input  wire logic        clk,
    input  wire logic        rst,
    input  wire logic        ddr_init,
    axi_rd_ctrl_mc_if.master bus
);
    localparam int c_AW  = P_AXI_ADDR_WIDTH;
    localparam int c_AW1 = P_AXI_ADDR_WIDTH + 1;
    localparam int c_BEAT = P_AXI_DATA_WIDTH / 8;
    localparam logic [c_AW1-1:0] c_RD_LEN   = c_AW1'(P_RD_LENGTH);
    localparam logic [c_AW1-1:0] c_BEAT_W   = c_AW1'(c_BEAT);
    localparam logic [c_AW1-1:0] c_ONE      = c_AW1'(1);
    localparam logic [7:0]       c_FULL_LEN = 8'(P_RD_LENGTH / c_BEAT - 1);
    localparam logic [P_CH_ID_WIDTH-1:0] c_LAST_CH = P_CH_ID_WIDTH'(P_CH_NUM - 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_REQ  = 1'b1
    } state_t;

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic                      w_load;
    logic                      w_hs;

    logic                      r_init_meta;
    logic                      r_init_sync;
    logic [P_CH_NUM-1:0]       r_ri;
    logic [P_CH_NUM-1:0]       r_ri_1d;
    logic [P_CH_NUM-1:0]       w_edge;
    logic [P_CH_NUM-1:0]       r_pending;
    logic [P_CH_NUM-1:0]       w_pending_nxt;
    logic [P_CH_NUM-1:0]       w_busy;
    logic [P_CH_ID_WIDTH-1:0]  r_last_grant;

    logic [c_AW-1:0]           w_baddr [P_CH_NUM];
    logic [c_AW-1:0]           w_faddr [P_CH_NUM];
    logic [c_AW-1:0]           r_ptr   [P_CH_NUM];

    logic                      r_valid;
    logic [c_AW-1:0]           r_addr;
    logic [7:0]                r_len;
    logic [P_CH_ID_WIDTH-1:0]  r_id;

    logic                      w_found;
    logic [P_CH_ID_WIDTH-1:0]  w_grant;
    int                        w_idx;
    logic [P_CH_NUM-1:0]       w_rot;

    logic [c_AW-1:0]           w_grant_ptr;
    logic [c_AW-1:0]           w_grant_end;
    logic [c_AW-1:0]           w_cmd_base;
    logic [c_AW-1:0]           w_cmd_end;
    logic [c_AW1-1:0]          w_rem;
    logic [c_AW1-1:0]          w_tail_bytes;
    logic [7:0]                w_grant_len;
    logic [c_AW1-1:0]          w_cmd_bytes;
    logic [c_AW1-1:0]          w_cmd_next_raw;
    logic                      w_cmd_wrap;
    logic [c_AW-1:0]           w_cmd_next;

    for (genvar k = 0; k < P_CH_NUM; k++) begin : g_unpack
        assign w_baddr[k] = bus.user_baddr[k*c_AW +: c_AW];
        assign w_faddr[k] = bus.user_faddr[k*c_AW +: c_AW];
    end

    assign w_edge = r_ri & ~r_ri_1d;
    assign w_hs   = (r_state == S_REQ) & r_valid & bus.axi_ready;

    // Round-robin: first pending channel strictly after the last grant
    always_comb begin
        w_found = 1'b0;
        w_grant = '0;
        w_idx   = 0;
        w_rot   = '0;
        for (int i = 1; i <= P_CH_NUM; i++) begin
            w_idx = int'(r_last_grant) + i;
            if (w_idx >= P_CH_NUM) begin
                w_idx = w_idx - P_CH_NUM;
            end
            w_rot = r_pending >> w_idx;
            if (!w_found && w_rot[0]) begin
                w_found = 1'b1;
                w_grant = P_CH_ID_WIDTH'(w_idx);
            end
        end
    end

    always_comb begin
        w_grant_ptr = '0;
        w_grant_end = '0;
        w_cmd_base  = '0;
        w_cmd_end   = '0;
        for (int k = 0; k < P_CH_NUM; k++) begin
            if (w_grant == P_CH_ID_WIDTH'(k)) begin
                w_grant_ptr = r_ptr[k];
                w_grant_end = w_faddr[k];
            end
            if (r_id == P_CH_ID_WIDTH'(k)) begin
                w_cmd_base = w_baddr[k];
                w_cmd_end  = w_faddr[k];
            end
        end
    end

    // One extra address bit keeps regions ending at the top of memory exact
    assign w_rem        = {1'b0, w_grant_end} - {1'b0, w_grant_ptr};
    assign w_tail_bytes = (w_rem < c_RD_LEN) ? w_rem : c_RD_LEN;
    assign w_grant_len  = (P_TAIL_EN != 0) ? 8'((w_tail_bytes / c_BEAT_W) - c_ONE) : c_FULL_LEN;

    assign w_cmd_bytes    = (c_AW1'(r_len) + c_ONE) * c_BEAT_W;
    assign w_cmd_next_raw = {1'b0, r_addr} + w_cmd_bytes;
    assign w_cmd_wrap     = (P_TAIL_EN != 0) ? (w_cmd_next_raw >= {1'b0, w_cmd_end})
                                             : ((w_cmd_next_raw + c_RD_LEN) > {1'b0, w_cmd_end});
    assign w_cmd_next     = w_cmd_wrap ? w_cmd_base : c_AW'(w_cmd_next_raw);

    // Clear beats handshake, handshake beats a new edge
    always_comb begin
        w_pending_nxt = r_pending;
        for (int k = 0; k < P_CH_NUM; k++) begin
            if (w_edge[k] && r_init_sync) begin
                w_pending_nxt[k] = 1'b1;
            end
            if (w_hs && (r_id == P_CH_ID_WIDTH'(k))) begin
                w_pending_nxt[k] = 1'b0;
            end
            if (bus.user_clr[k]) begin
                w_pending_nxt[k] = 1'b0;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_load      = 1'b1;
                    w_state_nxt = S_REQ;
                end
            end
            S_REQ: begin
                if (w_hs) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_init_meta  <= 1'b0;
            r_init_sync  <= 1'b0;
            r_ri         <= '0;
            r_ri_1d      <= '0;
            r_pending    <= '0;
            r_last_grant <= c_LAST_CH;
            r_valid      <= 1'b0;
            r_addr       <= '0;
            r_len        <= '0;
            r_id         <= '0;
            for (int k = 0; k < P_CH_NUM; k++) begin
                r_ptr[k] <= w_baddr[k];
            end
        end else begin
            r_init_meta <= ddr_init;
            r_init_sync <= r_init_meta;
            r_ri        <= bus.user_valid;
            r_ri_1d     <= r_ri;
            r_pending   <= w_pending_nxt;
            for (int k = 0; k < P_CH_NUM; k++) begin
                if (bus.user_clr[k]) begin
                    r_ptr[k] <= w_baddr[k];
                end else if (w_hs && (r_id == P_CH_ID_WIDTH'(k))) begin
                    r_ptr[k] <= w_cmd_next;
                end
            end
            if (w_hs) begin
                r_last_grant <= r_id;
                r_valid      <= 1'b0;
            end else if (w_load) begin
                r_valid <= 1'b1;
                r_addr  <= w_grant_ptr;
                r_len   <= w_grant_len;
                r_id    <= w_grant;
            end
        end
    end

    always_comb begin
        w_busy = r_pending;
        for (int k = 0; k < P_CH_NUM; k++) begin
            if ((r_state == S_REQ) && (r_id == P_CH_ID_WIDTH'(k))) begin
                w_busy[k] = 1'b1;
            end
        end
    end

    assign bus.user_busy  = w_busy;
    assign bus.u2a_valid  = r_valid;
    assign bus.u2a_addr   = r_addr;
    assign bus.u2a_length = r_len;
    assign bus.u2a_id     = r_id;
endmodule
`default_nettype wire
